// File: rtl/uart_pkg.sv
// Shared UART definitions: TX FSM state encoding, default payload width,
// frame-length constants and the default clock/baud figures used by the
// baud generator.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;
  localparam int UART_START_BITS = 1;
  localparam int UART_STOP_BITS  = 1;
  localparam int UART_CLOCK_FREQ = 1600000;
  localparam int UART_BAUD_RATE  = 10000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_state_e;

  // Baud periods from the start-bit falling edge to the end of the stop bit.
  function automatic int frame_bits(input int dw);
    return dw + UART_START_BITS + UART_STOP_BITS;
  endfunction

endpackage

// File: rtl/uart_baud_generator.sv
// Baud tick generator: one-clk pulse every CLOCK_FREQ/BAUD_RATE cycles.
// Ports:
//   clk       - system clock
//   rst       - asynchronous active-low reset
//   baud_tick - one-cycle pulse per bit period
module uart_baud_generator
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = UART_CLOCK_FREQ,
  parameter int BAUD_RATE  = UART_BAUD_RATE
) (
  input  logic clk,
  input  logic rst,
  output logic baud_tick
);

  localparam int DIV = CLOCK_FREQ / BAUD_RATE;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       cnt_q <= '0;
    else if (cnt_q == CW'(DIV - 1)) cnt_q <= '0;
    else                            cnt_q <= cnt_q + CW'(1);
  end

  // First tick lands DIV cycles after reset release.
  assign baud_tick = (cnt_q == CW'(DIV - 1));

endmodule

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin pick. The request vector is rotated so the
// requester after last_i sits at position 0, the lowest set bit is found,
// and the position is rotated back to a requester index.
// Ports:
//   req_i       - request vector
//   last_i      - index of the most recently granted requester
//   gnt_valid_o - at least one request present
//   gnt_idx_o   - index of the winner
//   gnt_oh_o    - one-hot winner (all zero when nothing requests)
module uart_rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] last_i,
  output logic                       gnt_valid_o,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o,
  output logic [NUM_REQ-1:0]         gnt_oh_o
);

  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] rot;
  int                 shift;
  int                 pos;

  always_comb begin
    // last_i + 1 never exceeds NUM_REQ, so a single wrap check suffices.
    shift = int'(last_i) + 1;
    if (shift >= NUM_REQ) shift = 0;

    // Rotate right by shift: rot[k] = req_i[(shift + k) mod NUM_REQ].
    rot = NUM_REQ'({req_i, req_i} >> shift);

    pos         = 0;
    gnt_valid_o = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        pos         = k;
        gnt_valid_o = 1'b1;
      end
    end

    pos = pos + shift;
    if (pos >= NUM_REQ) pos = pos - NUM_REQ;

    gnt_idx_o = IW'(pos);
    gnt_oh_o  = gnt_valid_o ? (NUM_REQ'(1) << pos) : '0;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// UART transmitter shared by NUM_REQ requesters with round-robin arbitration.
// Frames are 1 start bit, DATA_WIDTH data bits (LSB first), 1 stop bit; all
// state changes happen on baud_tick edges. A new frame can be accepted on the
// tick that ends a stop bit, giving back-to-back frames with no idle bit.
// Ports:
//   clk        - system clock
//   rst        - asynchronous active-low reset
//   baud_tick  - one-cycle pulse per bit period
//   req_valid  - per-requester frame request, held until accepted
//   req_data   - payloads, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready  - one-hot accept strobe (valid/ready handshake on the tick)
//   tx         - serial line, idle high
//   busy       - frame in flight
//   grant_id   - owner of current / most recent frame
//   frame_done - pulse on the tick that ends a stop bit
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          baud_tick,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          frame_done
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(DATA_WIDTH + 1);

  uart_state_e           state_q;
  logic                  tx_q;
  logic [DATA_WIDTH-1:0] sh_q;
  logic [CW-1:0]         cnt_q;
  logic [IW-1:0]         grant_q;
  logic [IW-1:0]         last_q;

  logic                  gnt_valid;
  logic [IW-1:0]         gnt_idx;
  logic [NUM_REQ-1:0]    gnt_oh;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [DATA_WIDTH-1:0] sh_next;
  logic                  accept;

  uart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i       (req_valid),
    .last_i      (last_q),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx),
    .gnt_oh_o    (gnt_oh)
  );

  // Acceptance is only possible from IDLE or at the end of STOP. rst gates
  // the strobe so nothing is handed out while reset is held.
  assign accept = rst & baud_tick & gnt_valid &
                  ((state_q == ST_IDLE) || (state_q == ST_STOP));

  assign req_ready  = accept ? gnt_oh : '0;
  assign frame_done = baud_tick & (state_q == ST_STOP);
  assign busy       = (state_q != ST_IDLE);
  assign tx         = tx_q;
  assign grant_id   = grant_q;
  assign sh_next    = sh_q >> 1;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt_oh[i]) sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      tx_q    <= 1'b1;
      sh_q    <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      last_q  <= IW'(NUM_REQ - 1);  // requester 0 searched first
    end else if (baud_tick) begin
      if (accept) begin
        state_q <= ST_START;
        tx_q    <= 1'b0;
        sh_q    <= sel_data;
        cnt_q   <= '0;
        grant_q <= gnt_idx;
        last_q  <= gnt_idx;
      end else begin
        unique case (state_q)
          ST_IDLE: ;
          ST_START: begin
            state_q <= ST_DATA;
            tx_q    <= sh_q[0];
          end
          ST_DATA: begin
            sh_q  <= sh_next;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(DATA_WIDTH - 1)) begin
              state_q <= ST_STOP;
              tx_q    <= 1'b1;
            end else begin
              tx_q <= sh_next[0];
            end
          end
          ST_STOP: begin
            state_q <= ST_IDLE;
            tx_q    <= 1'b1;
          end
          default: begin
            state_q <= ST_IDLE;
            tx_q    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter driven by uart_baud_generator
// (160 clk per bit). Stimulus pushes expected {requester, byte} entries to a
// scoreboard; a line monitor decodes frames from tx and pops/compares them.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;

  typedef struct {
    int         id;
    logic [7:0] data;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           baud_tick;
  logic [NR-1:0]  req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]  req_ready;
  logic           tx;
  logic           busy;
  logic [1:0]     grant_id;
  logic           frame_done;

  exp_t sb[$];
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   frames_rx = 0;
  int   b2b       = 0;
  int   t_end     = 0;
  int   cyc       = 0;

  logic [3:0] fair_exp [4] = '{4'b0001, 4'b1000, 4'b0001, 4'b1000};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_baud_generator #(.CLOCK_FREQ(1600000), .BAUD_RATE(10000)) u_baud (
    .clk       (clk),
    .rst       (rst),
    .baud_tick (baud_tick)
  );

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .baud_tick  (baud_tick),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .tx         (tx),
    .busy       (busy),
    .grant_id   (grant_id),
    .frame_done (frame_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int id, input logic [7:0] d);
    exp_t e;
    e.id   = id;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic set_req(input int id, input logic [7:0] d);
    req_data[id*DW +: DW] = d;
    req_valid[id]         = 1'b1;
  endtask

  // Returns at the negedge after the acceptance edge.
  task automatic wait_accept(input string tag, input logic [3:0] exp);
    int n = 0;
    while (req_ready == '0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(req_ready), 32'(exp));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_frames(input int target);
    int n = 0;
    while (frames_rx < target && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("frames_reached", frames_rx, target);
  endtask

  // Line monitor: a bit period starts at each tick edge, so tx is read at
  // the negedge following a tick. mst: 0 idle, 1 data, 2 stop bit, 3 in stop.
  initial begin : monitor
    int         mst = 0;
    int         mnb = 0;
    int         mid = 0;
    logic [7:0] mbits = '0;
    logic       prev_tick = 1'b0;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mst       = 0;
        prev_tick = 1'b0;
      end else begin
        if (baud_tick) check("frame_done", 32'(frame_done), 32'(mst == 3));
        if (prev_tick) begin
          case (mst)
            0: if (tx == 1'b0) begin mst = 1; mnb = 0; mid = int'(grant_id); end
            1: begin
              mbits = {tx, mbits[7:1]};
              mnb++;
              if (mnb == 8) mst = 2;
            end
            2: begin
              check("stop_bit", 32'(tx), 32'd1);
              mst = 3;
            end
            default: begin
              frames_rx++;
              t_end = cyc;
              check("sb_pending", 32'(sb.size() != 0), 32'd1);
              if (sb.size() != 0) begin
                e = sb.pop_front();
                check("frame_id", mid, e.id);
                check("frame_data", 32'(mbits), 32'(e.data));
              end
              if (tx == 1'b0) begin
                mst = 1; mnb = 0; mid = int'(grant_id); b2b++;
              end else begin
                mst = 0;
              end
            end
          endcase
        end
        prev_tick = baud_tick;
      end
    end
  end

  initial begin : stim
    int t0, f0, b0, seen, n;
    req_valid = '0;
    req_data  = '0;
    rst       = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_tx",         32'(tx),         32'd1);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_req_ready",  32'(req_ready),  32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_grant_id",   32'(grant_id),   32'd0);
    rst = 1'b1;

    // Single request, 0xA5 from requester 2.
    set_req(2, 8'hA5);
    push(2, 8'hA5);
    wait_accept("t1_ready", 4'b0100);
    req_valid[2] = 1'b0;
    t0 = cyc;
    check("t1_grant_id", 32'(grant_id), 32'd2);
    check("t1_busy",     32'(busy),     32'd1);
    check("t1_tx_start", 32'(tx),       32'd0);
    wait_frames(1);
    check("t1_len", t_end - t0, 1600);
    repeat (480) @(negedge clk);
    check("t1_idle_tx",   32'(tx),   32'd1);
    check("t1_idle_busy", 32'(busy), 32'd0);

    // Request withdrawn between ticks is never granted.
    n = 0;
    while (!baud_tick && n < 400) begin @(negedge clk); n++; end
    @(negedge clk);
    set_req(1, 8'h99);
    seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (req_ready != '0) seen++;
    end
    req_valid[1] = 1'b0;
    repeat (300) @(negedge clk);
    check("drop_no_grant", seen, 0);
    check("drop_busy",     32'(busy), 32'd0);
    check("drop_frames",   frames_rx, 1);

    // Payload changed mid-frame; transmitted byte is the accepted one.
    set_req(1, 8'h3C);
    push(1, 8'h3C);
    wait_accept("t3_ready", 4'b0010);
    req_valid[1] = 1'b0;
    repeat (400) @(negedge clk);
    req_data[1*DW +: DW] = 8'hFF;
    wait_frames(2);
    repeat (480) @(negedge clk);
    check("t3_idle_tx",  32'(tx),       32'd1);
    check("t3_idle_busy",32'(busy),     32'd0);
    check("t3_grant_id", 32'(grant_id), 32'd1);

    // All four from reset: grants 0,1,2,3 back to back.
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t2_rst_grant_id", 32'(grant_id), 32'd0);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_req(k, 8'((k + 1) * 8'h11));
      push(k, 8'((k + 1) * 8'h11));
    end
    b0 = b2b;
    f0 = frames_rx;
    for (int k = 0; k < 4; k++) begin
      wait_accept("t2_ready", 4'(1 << k));
      if (k == 0) t0 = cyc;
      req_valid[k] = 1'b0;
    end
    wait_frames(f0 + 4);
    check("t2_len", t_end - t0, 6400);
    check("t2_b2b", b2b - b0, 3);

    // Fairness: 0 and 3 held valid, grants alternate.
    set_req(0, 8'h81);
    set_req(3, 8'h7E);
    push(0, 8'h81); push(3, 8'h7E); push(0, 8'h81); push(3, 8'h7E);
    f0 = frames_rx;
    for (int k = 0; k < 4; k++) wait_accept("fair_ready", fair_exp[k]);
    req_valid = '0;
    wait_frames(f0 + 4);

    // Reset during data bit 4, pending requester 3 restarts afterwards.
    set_req(1, 8'h5A);
    push(1, 8'h5A);
    wait_accept("rst_pre_ready", 4'b0010);
    req_valid[1] = 1'b0;
    set_req(3, 8'hC3);
    push(3, 8'hC3);
    repeat (880) @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    void'(sb.pop_front());
    f0 = frames_rx;
    rst = 1'b0;
    #1;
    check("mid_rst_tx",         32'(tx),         32'd1);
    check("mid_rst_busy",       32'(busy),       32'd0);
    check("mid_rst_frame_done", 32'(frame_done), 32'd0);
    check("mid_rst_req_ready",  32'(req_ready),  32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    check("mid_no_frame", frames_rx, f0);
    wait_accept("rst_restart_ready", 4'b1000);
    t0 = cyc;
    req_valid[3] = 1'b0;
    wait_frames(f0 + 1);
    check("rst_restart_len", t_end - t0, 1600);
    check("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one UART TX line; legal range 2..8.
REQ-002 Parameter DATA_WIDTH, default 8: payload bits per frame, LSB first.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 baud_tick  input  1  one-clk pulse per bit period, from uart_baud_generator.
REQ-006 req_valid  input  NUM_REQ  per-requester frame request; held until accepted.
REQ-007 req_data  input  NUM_REQ*DATA_WIDTH  payload; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 req_ready  output  NUM_REQ  one-hot, one-clk accept pulse to the granted requester.
REQ-009 tx  output  1  serial line; idle high.
REQ-010 busy  output  1  high while a frame is on the line (START..STOP).
REQ-011 grant_id  output  clog2(NUM_REQ)  index of the requester owning the current or most recent frame.
REQ-012 frame_done  output  1  one-clk pulse on the baud_tick that ends a stop bit.

Function
REQ-013 FSM states IDLE, START, DATA, STOP; every state transition occurs only on a clk edge where baud_tick=1.
REQ-014 IDLE: tx=1, busy=0; on baud_tick with any req_valid high, accept one requester, load shift register, clear bit counter, go to START.
REQ-015 Acceptance: req_ready[g]=1 for exactly the acceptance cycle; all other req_ready bits 0; grant_id=g from the next cycle.
REQ-016 Round-robin arbitration: search starts at last_grant+1 modulo NUM_REQ; first valid requester wins; last_grant updates only on acceptance.
REQ-017 START: tx=0 for one full bit period; next baud_tick goes to DATA.
REQ-018 DATA: tx = shift register LSB; each baud_tick shifts right and increments the counter; after DATA_WIDTH bits, go to STOP.
REQ-019 STOP: tx=1 for one bit period; on the ending baud_tick pulse frame_done.
REQ-020 Back-to-back: on the STOP-ending baud_tick, if any req_valid is high, arbitrate and accept in that same cycle and go directly to START, with no idle bit; otherwise go to IDLE.
REQ-021 Frame length: exactly DATA_WIDTH+2 baud periods from tx falling edge to end of stop bit.
REQ-022 req_valid and req_data are sampled only at acceptance; changes during a frame do not affect the frame in flight.
REQ-023 A requester that drops req_valid before acceptance is not granted; no state is kept for it.
REQ-024 baud_tick high while no request is valid in IDLE: no state change, no outputs change.
REQ-025 Bit counter width is clog2(DATA_WIDTH+1); no wrap occurs within a frame.

Reset
REQ-026 While rst=0: state=IDLE, tx=1, busy=0, req_ready=0, frame_done=0, grant_id=0, last_grant=NUM_REQ-1 (requester 0 has first priority), shift register and counter 0.
REQ-027 Reset asserted mid-frame aborts the frame immediately; tx returns to 1 asynchronously; no frame_done pulse.
REQ-028 After reset release, the first acceptance occurs on the first baud_tick that coincides with a valid request.

Structure
REQ-029 Package uart_pkg holds the FSM state enum, DATA_WIDTH default and the shared frame-length constants; uart_baud_generator and this block both import it.
REQ-030 The round-robin pick (priority rotate, find-first, unrotate) is a combinational sub-module, uart_rr_arbiter; the FSM and shift path stay in uart_tx_arbiter.
REQ-031 The block does not instantiate the baud generator; the integrating top connects baud_tick.

Verification
REQ-032 The bench connects uart_baud_generator (CLOCK_FREQ=1600000, BAUD_RATE=10000, baud_tick every 160 clk).
REQ-033 Single request: req_valid[2]=1, data 0xA5 -> req_ready[2] one pulse; tx bit sequence 0,1,0,1,0,0,1,0,1,1; frame_done after 1600 clk; grant_id=2.
REQ-034 All four valid from reset, data 0x11/0x22/0x33/0x44 -> grants in order 0,1,2,3; four frames back-to-back with no idle bit; 6400 clk in total.
REQ-035 Fairness: requesters 0 and 3 continuously valid -> grants alternate 0,3,0,3; neither is starved.
REQ-036 Reset is pulled low at DATA bit 4 -> tx=1 within the same cycle, busy=0, no frame_done; after release, a pending request restarts with a full frame.
REQ-037 req_data changes during DATA -> the transmitted byte equals the value latched at acceptance; a single request with no competitor -> IDLE after STOP, tx stays high.
